// File: rtl/cnn_eai_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_eai_seq
//  Brief    : EAI coprocessor sequencer for the CNN accelerator. Decodes
//             LDK/RUN custom instructions, moves image/kernel/output words
//             over the EAI ICB port one transaction at a time, handshakes
//             with the convolution core and returns one EAI response.
//  Options  : CNN_EAI_ADDR_CHECK_EN - reject word-misaligned rs1/rs2
//             (otherwise address bits [1:0] are forced to zero).
//  Revision : 1.0 - initial release
// ============================================================================
module cnn_eai_seq #(
    parameter int IMG_DIM         = 7,
    parameter int K_DIM           = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int INSTR_WIDTH     = 32,
    parameter int DISP_ITAG_WIDTH = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             eai_req_valid,
    output logic                                             eai_req_ready,
    input  logic [INSTR_WIDTH-1:0]                           eai_req_instr,
    input  logic [DATA_WIDTH-1:0]                            eai_req_rs1,
    input  logic [DATA_WIDTH-1:0]                            eai_req_rs2,
    input  logic [DISP_ITAG_WIDTH-1:0]                       eai_req_itag,
    output logic                                             eai_rsp_valid,
    input  logic                                             eai_rsp_ready,
    output logic [DATA_WIDTH-1:0]                            eai_rsp_wdat,
    output logic [DISP_ITAG_WIDTH-1:0]                       eai_rsp_itag,
    output logic                                             eai_rsp_err,
    output logic                                             eai_icb_cmd_valid,
    input  logic                                             eai_icb_cmd_ready,
    output logic [DATA_WIDTH-1:0]                            eai_icb_cmd_addr,
    output logic                                             eai_icb_cmd_read,
    output logic [DATA_WIDTH-1:0]                            eai_icb_cmd_wdata,
    output logic [3:0]                                       eai_icb_cmd_wmask,
    input  logic                                             eai_icb_rsp_valid,
    output logic                                             eai_icb_rsp_ready,
    input  logic [DATA_WIDTH-1:0]                            eai_icb_rsp_rdata,
    input  logic                                             eai_icb_rsp_err,
    output logic                                             eai_mem_holdup,
    output logic                                             conv_start,
    input  logic                                             conv_done,
    output logic [IMG_DIM*IMG_DIM*16-1:0]                    conv_x,
    output logic [K_DIM*K_DIM*16-1:0]                        conv_kernel,
    input  logic [(IMG_DIM-K_DIM+1)*(IMG_DIM-K_DIM+1)*16-1:0] conv_out
);

    localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
    localparam int IMG_N   = IMG_DIM * IMG_DIM;
    localparam int K_N     = K_DIM * K_DIM;
    localparam int OUT_N   = OUT_DIM * OUT_DIM;
    localparam int IMG_W   = (IMG_N + 1) / 2;
    localparam int K_W     = (K_N + 1) / 2;
    localparam int OUT_W   = (OUT_N + 1) / 2;
    localparam int IDX_W   = $clog2(IMG_W + 1);
    localparam bit OUT_ODD = (OUT_N % 2) == 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_CMD = 3'd1,
        S_RD_RSP = 3'd2,
        S_CONV   = 3'd3,
        S_WR_CMD = 3'd4,
        S_WR_RSP = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic                         r_is_run;
    logic [DISP_ITAG_WIDTH-1:0]   r_itag;
    logic [DATA_WIDTH-1:0]        r_addr;
    logic [DATA_WIDTH-1:0]        r_dst;
    logic [DATA_WIDTH-1:0]        r_beats;
    logic [IDX_W-1:0]             r_word_idx;
    logic                         r_err;
    logic                         r_conv_start;
    logic [K_N*16-1:0]            r_kbuf;
    logic [IMG_N*16-1:0]          r_xbuf;
    logic [OUT_N*16-1:0]          r_obuf;

    logic [2:0]                   w_funct3;
    logic                         w_is_ldk;
    logic                         w_is_run;
    logic                         w_misalign;
    logic                         w_legal;
    logic                         w_last_rd;
    logic                         w_last_wr;
    logic                         w_conv_fire;
    logic [DATA_WIDTH-1:0]        w_wdata;
    logic                         w_unused_bits;

    assign w_funct3 = eai_req_instr[14:12];
    assign w_is_ldk = (w_funct3 == 3'b000);
    assign w_is_run = (w_funct3 == 3'b001);

`ifdef CNN_EAI_ADDR_CHECK_EN
    assign w_misalign = (eai_req_rs1[1:0] != 2'b00) ||
                        (w_is_run && (eai_req_rs2[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_legal     = (w_is_ldk || w_is_run) && !w_misalign;
    assign w_last_rd   = r_is_run ? (r_word_idx == IDX_W'(IMG_W - 1))
                                  : (r_word_idx == IDX_W'(K_W - 1));
    assign w_last_wr   = (r_word_idx == IDX_W'(OUT_W - 1));
    // A done arriving together with the start pulse belongs to no run of ours
    assign w_conv_fire = conv_done && !r_conv_start;

    assign w_unused_bits = ^{eai_req_instr[INSTR_WIDTH-1:15], eai_req_instr[11:0],
                             eai_req_rs1[1:0], eai_req_rs2[1:0]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: one ICB transaction outstanding at a time
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (eai_req_valid) w_next = w_legal ? S_RD_CMD : S_RESP;
            S_RD_CMD: if (eai_icb_cmd_ready) w_next = S_RD_RSP;
            S_RD_RSP: begin
                if (eai_icb_rsp_valid) begin
                    if (eai_icb_rsp_err)  w_next = S_RESP;
                    else if (w_last_rd)   w_next = r_is_run ? S_CONV : S_RESP;
                    else                  w_next = S_RD_CMD;
                end
            end
            S_CONV:   if (w_conv_fire) w_next = S_WR_CMD;
            S_WR_CMD: if (eai_icb_cmd_ready) w_next = S_WR_RSP;
            S_WR_RSP: begin
                if (eai_icb_rsp_valid) begin
                    w_next = (eai_icb_rsp_err || w_last_wr) ? S_RESP : S_WR_CMD;
                end
            end
            S_RESP:   if (eai_rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request capture, address/beat/word stepping, buffer fill and output capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_run     <= 1'b0;
            r_itag       <= '0;
            r_addr       <= '0;
            r_dst        <= '0;
            r_beats      <= '0;
            r_word_idx   <= '0;
            r_err        <= 1'b0;
            r_conv_start <= 1'b0;
            r_kbuf       <= '0;
            r_xbuf       <= '0;
            r_obuf       <= '0;
        end else begin
            r_conv_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (eai_req_valid) begin
                        r_itag     <= eai_req_itag;
                        r_is_run   <= w_is_run;
                        r_addr     <= {eai_req_rs1[DATA_WIDTH-1:2], 2'b00};
                        r_dst      <= {eai_req_rs2[DATA_WIDTH-1:2], 2'b00};
                        r_beats    <= '0;
                        r_word_idx <= '0;
                        r_err      <= !w_legal;
                    end
                end
                S_RD_RSP: begin
                    if (eai_icb_rsp_valid) begin
                        r_beats    <= r_beats + DATA_WIDTH'(1);
                        r_addr     <= r_addr + DATA_WIDTH'(4);
                        r_word_idx <= r_word_idx + IDX_W'(1);
                        if (eai_icb_rsp_err) begin
                            r_err <= 1'b1;
                        end else begin
                            // Only elements that live in this word are written; an odd
                            // tail element leaves the upper half of the last word unused
                            for (int e = 0; e < K_N; e++) begin
                                if (!r_is_run && (r_word_idx == IDX_W'(e / 2)))
                                    r_kbuf[e*16 +: 16] <= eai_icb_rsp_rdata[(e % 2)*16 +: 16];
                            end
                            for (int e = 0; e < IMG_N; e++) begin
                                if (r_is_run && (r_word_idx == IDX_W'(e / 2)))
                                    r_xbuf[e*16 +: 16] <= eai_icb_rsp_rdata[(e % 2)*16 +: 16];
                            end
                            if (w_last_rd && r_is_run) r_conv_start <= 1'b1;
                        end
                    end
                end
                S_CONV: begin
                    if (w_conv_fire) begin
                        r_obuf     <= conv_out;
                        r_addr     <= r_dst;
                        r_word_idx <= '0;
                    end
                end
                S_WR_RSP: begin
                    if (eai_icb_rsp_valid) begin
                        r_beats    <= r_beats + DATA_WIDTH'(1);
                        r_addr     <= r_addr + DATA_WIDTH'(4);
                        r_word_idx <= r_word_idx + IDX_W'(1);
                        if (eai_icb_rsp_err) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack the two output elements of the current word; missing odd tail reads as zero
    always_comb begin
        w_wdata = '0;
        for (int e = 0; e < OUT_N; e++) begin
            if (r_word_idx == IDX_W'(e / 2))
                w_wdata[(e % 2)*16 +: 16] = r_obuf[e*16 +: 16];
        end
    end

    // Ready is withheld while reset is applied so every output reads zero then
    assign eai_req_ready     = (r_state == S_IDLE) && !rst;
    assign eai_icb_cmd_valid = (r_state == S_RD_CMD) || (r_state == S_WR_CMD);
    assign eai_icb_cmd_read  = (r_state == S_RD_CMD);
    assign eai_icb_cmd_addr  = eai_icb_cmd_valid ? r_addr : '0;
    assign eai_icb_cmd_wdata = (r_state == S_WR_CMD) ? w_wdata : '0;
    assign eai_icb_cmd_wmask = (r_state != S_WR_CMD) ? 4'b0000 :
                               (OUT_ODD && w_last_wr) ? 4'b0011 : 4'b1111;
    assign eai_icb_rsp_ready = (r_state == S_RD_RSP) || (r_state == S_WR_RSP);
    assign eai_mem_holdup    = (r_state != S_IDLE) && (r_state != S_RESP);
    assign eai_rsp_valid     = (r_state == S_RESP);
    assign eai_rsp_wdat      = eai_rsp_valid ? r_beats : '0;
    assign eai_rsp_itag      = eai_rsp_valid ? r_itag : '0;
    assign eai_rsp_err       = eai_rsp_valid && r_err;
    assign conv_start        = r_conv_start;
    assign conv_x            = r_xbuf;
    assign conv_kernel       = r_kbuf;

endmodule
`default_nettype wire

// File: tb/tb_cnn_eai_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnn_eai_seq
//  Brief    : Directed self-checking bench for cnn_eai_seq with a word memory
//             responder (optional stalls / error injection) and a conv-core model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_eai_seq;

    localparam int IMG_N = 49;
    localparam int K_N   = 9;
    localparam int OUT_N = 25;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               eai_req_valid = 1'b0;
    logic               eai_req_ready;
    logic [31:0]        eai_req_instr = '0;
    logic [31:0]        eai_req_rs1 = '0;
    logic [31:0]        eai_req_rs2 = '0;
    logic [1:0]         eai_req_itag = '0;
    logic               eai_rsp_valid;
    logic               eai_rsp_ready = 1'b0;
    logic [31:0]        eai_rsp_wdat;
    logic [1:0]         eai_rsp_itag;
    logic               eai_rsp_err;
    logic               eai_icb_cmd_valid;
    logic               eai_icb_cmd_ready = 1'b0;
    logic [31:0]        eai_icb_cmd_addr;
    logic               eai_icb_cmd_read;
    logic [31:0]        eai_icb_cmd_wdata;
    logic [3:0]         eai_icb_cmd_wmask;
    logic               eai_icb_rsp_valid = 1'b0;
    logic               eai_icb_rsp_ready;
    logic [31:0]        eai_icb_rsp_rdata = '0;
    logic               eai_icb_rsp_err = 1'b0;
    logic               eai_mem_holdup;
    logic               conv_start;
    logic               conv_done = 1'b0;
    logic [IMG_N*16-1:0] conv_x;
    logic [K_N*16-1:0]   conv_kernel;
    logic [OUT_N*16-1:0] conv_out = '0;

    cnn_eai_seq dut (
        .clk               (clk),
        .rst               (rst),
        .eai_req_valid     (eai_req_valid),
        .eai_req_ready     (eai_req_ready),
        .eai_req_instr     (eai_req_instr),
        .eai_req_rs1       (eai_req_rs1),
        .eai_req_rs2       (eai_req_rs2),
        .eai_req_itag      (eai_req_itag),
        .eai_rsp_valid     (eai_rsp_valid),
        .eai_rsp_ready     (eai_rsp_ready),
        .eai_rsp_wdat      (eai_rsp_wdat),
        .eai_rsp_itag      (eai_rsp_itag),
        .eai_rsp_err       (eai_rsp_err),
        .eai_icb_cmd_valid (eai_icb_cmd_valid),
        .eai_icb_cmd_ready (eai_icb_cmd_ready),
        .eai_icb_cmd_addr  (eai_icb_cmd_addr),
        .eai_icb_cmd_read  (eai_icb_cmd_read),
        .eai_icb_cmd_wdata (eai_icb_cmd_wdata),
        .eai_icb_cmd_wmask (eai_icb_cmd_wmask),
        .eai_icb_rsp_valid (eai_icb_rsp_valid),
        .eai_icb_rsp_ready (eai_icb_rsp_ready),
        .eai_icb_rsp_rdata (eai_icb_rsp_rdata),
        .eai_icb_rsp_err   (eai_icb_rsp_err),
        .eai_mem_holdup    (eai_mem_holdup),
        .conv_start        (conv_start),
        .conv_done         (conv_done),
        .conv_x            (conv_x),
        .conv_kernel       (conv_kernel),
        .conv_out          (conv_out)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem [0:1023];
    logic [31:0] exp_wr [0:12];
    logic [3:0]  exp_mask [0:12];
    int          stall = 0;
    int          err_beat = 0;
    int          rd_cmds = 0;
    int          wr_cmds = 0;
    int          rd_beats = 0;
    int          n_starts = 0;
    logic [31:0] exp_rd_addr = '0;
    logic [31:0] exp_wr_addr = '0;
    // responder state
    logic        pend = 1'b0;
    logic        p_read;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_mask;
    logic        held = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_read;
    logic [3:0]  h_mask;
    logic [15:0] old_k [0:K_N-1];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_elem(input int base_word, input int e);
        logic [31:0] w;
        w = mem[base_word + e / 2];
        return (e % 2 == 1) ? w[31:16] : w[15:0];
    endfunction

    // Memory responder: decides handshakes at the falling edge for the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0; held = 1'b0;
                eai_icb_cmd_ready = 1'b0; eai_icb_rsp_valid = 1'b0; eai_icb_rsp_err = 1'b0;
            end else begin
                if (pend) begin
                    if (stall == 0 || $urandom_range(0, 2) == 0) begin
                        eai_icb_rsp_valid = 1'b1;
                        eai_icb_rsp_err   = p_read && (err_beat != 0) && (rd_beats + 1 == err_beat);
                        eai_icb_rsp_rdata = p_read ? mem[p_addr[11:2]] : 32'h0;
                        if (eai_icb_rsp_ready) begin
                            if (p_read) rd_beats++;
                            else begin
                                for (int b = 0; b < 4; b++)
                                    if (p_mask[b]) mem[p_addr[11:2]][b*8 +: 8] = p_wdata[b*8 +: 8];
                            end
                            pend = 1'b0;
                        end
                    end else begin
                        eai_icb_rsp_valid = 1'b0; eai_icb_rsp_err = 1'b0;
                    end
                end else begin
                    // stray responses outside a transaction must be ignored
                    eai_icb_rsp_valid = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    eai_icb_rsp_err   = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    eai_icb_rsp_rdata = 32'hDEAD_BEEF;
                end
                if (held) begin
                    check_val("stall_valid", eai_icb_cmd_valid, 1);
                    check_val("stall_addr",  eai_icb_cmd_addr, h_addr);
                    check_val("stall_read",  eai_icb_cmd_read, h_read);
                    check_val("stall_wdata", eai_icb_cmd_wdata, h_wdata);
                    check_val("stall_wmask", eai_icb_cmd_wmask, h_mask);
                end
                held = 1'b0;
                eai_icb_cmd_ready = (stall == 0) || ($urandom_range(0, 1) == 0);
                if (eai_icb_cmd_valid && !pend) begin
                    if (eai_icb_cmd_ready) begin
                        pend = 1'b1; p_read = eai_icb_cmd_read; p_addr = eai_icb_cmd_addr;
                        p_wdata = eai_icb_cmd_wdata; p_mask = eai_icb_cmd_wmask;
                        if (p_read) begin
                            check_val("rd_addr", p_addr, exp_rd_addr);
                            exp_rd_addr = exp_rd_addr + 4;
                            rd_cmds++;
                        end else begin
                            check_val("wr_addr", p_addr, exp_wr_addr);
                            if (wr_cmds < 13) begin
                                check_val("wr_data", p_wdata, exp_wr[wr_cmds]);
                                check_val("wr_mask", p_mask, exp_mask[wr_cmds]);
                            end
                            exp_wr_addr = exp_wr_addr + 4;
                            wr_cmds++;
                        end
                    end else begin
                        held = 1'b1; h_addr = eai_icb_cmd_addr; h_read = eai_icb_cmd_read;
                        h_wdata = eai_icb_cmd_wdata; h_mask = eai_icb_cmd_wmask;
                    end
                end
            end
        end
    end

    // Convolution core model: a stray done with the start pulse, the real one 3 cycles later
    initial begin
        forever begin
            @(negedge clk);
            conv_done = 1'b0;
            if (!rst && conv_start) begin
                n_starts++;
                conv_out  = '0;
                conv_done = 1'b1;
                @(negedge clk);
                conv_done = 1'b0;
                check_val("start_pulse", conv_start, 0);
                @(negedge clk);
                @(negedge clk);
                for (int n = 0; n < OUT_N; n++) conv_out[n*16 +: 16] = 16'(n + 1);
                conv_done = 1'b1;
            end
        end
    end

    task automatic start_test(input logic [31:0] rd_base, input logic [31:0] wr_base);
        exp_rd_addr = rd_base; exp_wr_addr = wr_base;
        rd_cmds = 0; wr_cmds = 0; rd_beats = 0; n_starts = 0;
    endtask

    task automatic send_req(input logic [2:0] f3, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [1:0] tag);
        int n;
        @(negedge clk);
        eai_req_valid = 1'b1;
        eai_req_instr = {17'h0, f3, 5'h0, 7'h0B};
        eai_req_rs1 = rs1; eai_req_rs2 = rs2; eai_req_itag = tag;
        n = 0;
        while (!eai_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        eai_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [31:0] wdat,
                            input logic err, input logic [1:0] tag);
        int n;
        n = 0;
        while (!eai_rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val({name, "_rsp_seen"}, eai_rsp_valid, 1);
        check_val({name, "_wdat"}, eai_rsp_wdat, wdat);
        check_val({name, "_err"}, eai_rsp_err, err);
        check_val({name, "_itag"}, eai_rsp_itag, tag);
        check_val({name, "_holdup"}, eai_mem_holdup, 0);
        repeat (2) @(negedge clk);
        check_val({name, "_rsp_hold"}, eai_rsp_valid, 1);
        eai_rsp_ready = 1'b1;
        @(negedge clk);
        eai_rsp_ready = 1'b0;
        check_val({name, "_rsp_drop"}, eai_rsp_valid, 0);
    endtask

    task automatic run_and_check(input string name);
        for (int i = 256; i < 268; i++) mem[i] = 32'h0;
        mem[268] = 32'hFFFF_FFFF;
        start_test(32'h200, 32'h400);
        send_req(3'b001, 32'h200, 32'h400, 2'd1);
        wait_rsp(name, 32'd38, 1'b0, 2'd1);
        check_val({name, "_reads"}, rd_cmds, 25);
        check_val({name, "_writes"}, wr_cmds, 13);
        check_val({name, "_starts"}, n_starts, 1);
        for (int e = 0; e < IMG_N; e++) check_val({name, "_img"}, conv_x[e*16 +: 16], mem_elem(128, e));
        for (int i = 0; i < 12; i++) check_val({name, "_mem"}, mem[256 + i], exp_wr[i]);
        check_val({name, "_mem_last"}, mem[268], 32'hFFFF_0019);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {16'(i * 7 + 3), 16'(i * 13 + 1)};
        for (int i = 0; i < 12; i++) begin
            exp_wr[i]   = {16'(2 * i + 2), 16'(2 * i + 1)};
            exp_mask[i] = 4'b1111;
        end
        exp_wr[12]   = 32'h0000_0019;
        exp_mask[12] = 4'b0011;

        // reset values
        repeat (3) @(negedge clk);
        check_val("rst_req_ready", eai_req_ready, 0);
        check_val("rst_cmd_valid", eai_icb_cmd_valid, 0);
        check_val("rst_rsp_valid", eai_rsp_valid, 0);
        check_val("rst_holdup", eai_mem_holdup, 0);
        check_val("rst_conv_start", conv_start, 0);
        check_val("rst_kernel", conv_kernel[63:0], 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_req_ready", eai_req_ready, 1);

        // LDK from 0x100
        start_test(32'h100, 32'h0);
        send_req(3'b000, 32'h100, 32'hFFFF_FFF0, 2'd2);
        check_val("ldk_cmd_t1", eai_icb_cmd_valid, 1);
        check_val("ldk_holdup", eai_mem_holdup, 1);
        wait_rsp("ldk", 32'd5, 1'b0, 2'd2);
        check_val("ldk_reads", rd_cmds, 5);
        for (int e = 0; e < K_N; e++) check_val("ldk_kernel", conv_kernel[e*16 +: 16], mem_elem(64, e));

        // RUN with an always-ready memory, then with random stalls
        run_and_check("run");
        stall = 1;
        run_and_check("run_stall");
        stall = 0;

        // LDK with an error on the third read
        for (int e = 0; e < K_N; e++) old_k[e] = mem_elem(64, e);
        mem[64] = 32'h1111_2222;
        mem[65] = 32'h3333_4444;
        err_beat = 3;
        start_test(32'h100, 32'h0);
        send_req(3'b000, 32'h100, 32'h0, 2'd3);
        wait_rsp("ldk_err", 32'd3, 1'b1, 2'd3);
        err_beat = 0;
        check_val("ldk_err_reads", rd_cmds, 3);
        check_val("ldk_err_k0", conv_kernel[15:0], 16'h2222);
        check_val("ldk_err_k3", conv_kernel[63:48], 16'h3333);
        for (int e = 6; e < K_N; e++) check_val("ldk_err_kold", conv_kernel[e*16 +: 16], old_k[e]);

        // illegal funct3
        start_test(32'h0, 32'h0);
        send_req(3'b101, 32'h100, 32'h400, 2'd3);
        wait_rsp("illegal", 32'd0, 1'b1, 2'd3);
        check_val("illegal_cmds", rd_cmds + wr_cmds, 0);

`ifdef CNN_EAI_ADDR_CHECK_EN
        start_test(32'h0, 32'h0);
        send_req(3'b000, 32'h102, 32'h0, 2'd0);
        wait_rsp("misalign", 32'd0, 1'b1, 2'd0);
        check_val("misalign_cmds", rd_cmds + wr_cmds, 0);
`else
        start_test(32'h100, 32'h0);
        send_req(3'b000, 32'h102, 32'h0, 2'd0);
        wait_rsp("unaligned", 32'd5, 1'b0, 2'd0);
        check_val("unaligned_reads", rd_cmds, 5);
`endif

        // reset while a write command is pending
        stall = 1;
        start_test(32'h200, 32'h400);
        send_req(3'b001, 32'h200, 32'h400, 2'd1);
        begin
            int n;
            n = 0;
            while (!(eai_icb_cmd_valid && !eai_icb_cmd_read) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check_val("wr_cmd_reached", eai_icb_cmd_valid && !eai_icb_cmd_read, 1);
        end
        #1 rst = 1'b1;
        #1;
        check_val("arst_cmd_valid", eai_icb_cmd_valid, 0);
        check_val("arst_holdup", eai_mem_holdup, 0);
        check_val("arst_req_ready", eai_req_ready, 0);
        check_val("arst_rsp_valid", eai_rsp_valid, 0);
        check_val("arst_kernel", conv_kernel[63:0], 0);
        check_val("arst_img", conv_x[63:0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stall = 0;
        start_test(32'h100, 32'h0);
        repeat (3) @(negedge clk);
        check_val("post_rst_quiet", rd_cmds + wr_cmds, 0);
        check_val("post_rst_rsp", eai_rsp_valid, 0);
        send_req(3'b000, 32'h100, 32'h0, 2'd2);
        wait_rsp("post_rst_ldk", 32'd5, 1'b0, 2'd2);
        for (int e = 0; e < K_N; e++) check_val("post_rst_kernel", conv_kernel[e*16 +: 16], mem_elem(64, e));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnn_eai_seq.md
# cnn_eai_seq

Parametrised EAI coprocessor sequencer for the CNN accelerator on the E200 extension accelerator interface. It decodes a custom instruction and fetches an image or kernel over the EAI ICB memory port into internal buffers. For a run instruction it also drives the convolution core through a start/done handshake, writes the output map back to memory, and returns a single EAI response. The block replaces combinational address generation with a one-outstanding-transaction FSM.

## Interface

Parameters:
- IMG_DIM, 7, image side length in 16-bit elements.
- K_DIM, 3, kernel side length; OUT_DIM = IMG_DIM-K_DIM+1.
- DATA_WIDTH, 32, EAI/ICB data and address width.
- INSTR_WIDTH, 32, instruction width.
- DISP_ITAG_WIDTH, 2, instruction tag width.

Derived values:
- IMG_N = IMG_DIM², K_N = K_DIM², OUT_N = OUT_DIM².
- Word count for N elements is ceil(N/2).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- eai_req_valid / eai_req_ready, in/out, 1, request handshake.
- eai_req_instr, in, INSTR_WIDTH, instruction; funct3 = bits [14:12].
- eai_req_rs1 / eai_req_rs2, in, DATA_WIDTH, source address / destination address.
- eai_req_itag, in, DISP_ITAG_WIDTH, tag.
- eai_rsp_valid / eai_rsp_ready, out/in, 1, response handshake.
- eai_rsp_wdat, out, DATA_WIDTH, number of ICB beats completed.
- eai_rsp_itag, out, DISP_ITAG_WIDTH, captured tag.
- eai_rsp_err, out, 1, error flag.
- eai_icb_cmd_valid / eai_icb_cmd_ready, out/in, 1, memory command handshake.
- eai_icb_cmd_addr, out, DATA_WIDTH, memory address.
- eai_icb_cmd_read, out, 1, 1 = read.
- eai_icb_cmd_wdata, out, DATA_WIDTH, write data.
- eai_icb_cmd_wmask, out, 4, byte-enable mask.
- eai_icb_rsp_valid, in, 1, memory response valid.
- eai_icb_rsp_ready, out, 1, memory response ready.
- eai_icb_rsp_rdata, in, DATA_WIDTH, read data.
- eai_icb_rsp_err, in, 1, memory response error.
- eai_mem_holdup, out, 1, holds off core memory accesses.
- conv_start, out, 1, one-cycle pulse.
- conv_done, in, 1, one-cycle pulse.
- conv_x, out, IMG_N*16, image buffer.
- conv_kernel, out, K_N*16, kernel buffer.
- conv_out, in, OUT_N*16, convolution result.

## Operation

Instruction decode (funct3):
- 000 LDK: load K_N elements from rs1 into the kernel buffer; rs2 is ignored.
- 001 RUN: load IMG_N elements from rs1, pulse conv_start, wait for conv_done, capture conv_out, write OUT_N elements to rs2.
- Any other value is illegal: respond with err=1 and wdat=0; no ICB traffic.

Packing:
- Element n sits at bus bits [n*16+:16] and in memory word n/2; even n occupies bits [15:0].
- For an odd element count, the last read word's upper half is discarded.
- For an odd output count, the last write has wmask 4'b0011 and upper wdata 0. All other writes use 4'b1111.

FSM states:
- IDLE → RD_CMD on request handshake (LDK/RUN), or → RESP (illegal).
- RD_CMD → RD_RSP on command handshake.
- RD_RSP → RD_CMD (more words remain), CONV (RUN, last word), RESP (LDK, last word, or rsp_err).
- CONV → WR_CMD on conv_done.
- WR_CMD → WR_RSP on command handshake.
- WR_RSP → WR_CMD (more words remain) or RESP (last word, or rsp_err).
- RESP → IDLE on response handshake.

Handshakes and counters:
- eai_req_ready = 1 only in IDLE.
- eai_icb_rsp_ready = 1 in RD_RSP and WR_RSP.
- Address increments by 4 per beat and wraps modulo 2^DATA_WIDTH.
- The beat counter counts completed responses, including an erroring one. It is returned in wdat.

Errors:
- On rsp_err the remaining transfer is aborted and err=1 is returned.
- Buffers keep any words already written; the kernel buffer is not restored.

Other rules:
- RUN with no prior LDK uses the current kernel buffer contents (zero after reset).
- eai_mem_holdup = 1 from the cycle after request accept until entering RESP.

## Timing

- Reset values: every output 0; state IDLE; buffers and counters 0.
- Accept at edge T: cmd_valid rises at T+1. Each beat takes at least 2 cycles (command, then response), with one outstanding transaction.
- cmd_valid, addr, wdata and wmask are held stable until cmd_ready.
- eai_icb_rsp_valid outside RD_RSP/WR_RSP is ignored.
- conv_start is pulsed one cycle after the last read response. A conv_done in the same cycle as conv_start is ignored.
- rsp_valid rises the cycle after the terminating event and holds until rsp_ready.
- A reset mid-operation aborts immediately with no response and no further ICB commands.

## Configuration

- CNN_EAI_ADDR_CHECK_EN defined: rs1 (and rs2 for RUN) must have bits [1:0] = 0. A misaligned request gets err=1, wdat=0 and no ICB traffic.
- Undefined: address bits [1:0] are forced to 0 and no alignment error is raised.

## Test plan

- LDK at rs1=0x100, default params, always-ready memory → 5 reads at 0x100..0x110; kernel buffer matches memory; rsp wdat=5, err=0, itag echoed.
- RUN with rs1=0x200, rs2=0x400, conv_done 3 cycles after start, conv_out element n = n+1:
  - 25 reads at 0x200..0x260;
  - 13 writes at 0x400..0x430, last with wmask 0011 and wdata 0x00000019;
  - rsp wdat=38.
- Random cmd_ready/rsp_valid stalls during RUN → command fields stable while stalled; same final memory and wdat=38.
- rsp_err on 3rd read of LDK → no 4th command; err=1, wdat=3; holdup drops.
- funct3=3'b101 → immediate err=1, wdat=0, zero ICB commands. With CNN_EAI_ADDR_CHECK_EN, rs1=0x102 → err=1, wdat=0.
- Reset asserted during WR_CMD → all outputs 0 asynchronously; the next LDK completes normally.
